ascii_hex_parser: RTL and testbench
===================================

Name: ascii_hex_parser

Overview:
- Parses a stream of ASCII characters into binary words; the reverse direction of the debug nibble-to-ASCII path.
- Sits behind the debug UART receiver: consumes bytes over a valid/ready interface, accumulates hex digits, and emits one right-aligned word per delimited token.
- Tokens that are malformed or too long are flagged and dropped.

Parameters:
- WIDTH, 32, output word width in bits; must be a multiple of 4 and at least 4. MAXDIG = WIDTH/4 is derived, not overridable.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- char_in  input  8  ASCII character from the UART receiver.
- char_valid  input  1  char_in is valid.
- char_ready  output  1  block accepts a character this cycle.
- word_out  output  WIDTH  parsed word, zero-extended, right-aligned.
- word_valid  output  1  word_out is valid.
- word_ready  input  1  consumer accepts word_out.
- digit_count  output  clog2(MAXDIG+1)  digits accumulated in the current token.
- err  output  1  one-cycle pulse when a token is rejected.

Behaviour:
- One clock domain (clk). rst_n is asynchronous active-low.
- Reset state:
  - state=IDLE; accumulator=0; word_out=0; word_valid=0; digit_count=0; err=0.
  - char_ready=1 from the first clock after rst_n deasserts.
- char_ready is decoded from state: 1 in IDLE, ACCUM and DRAIN; 0 in OUTPUT.
- A character is consumed only when char_valid && char_ready.
- Character classes:
  - Digit: 0x30-0x39 gives value c-0x30; 0x41-0x46 gives c-0x37; 0x61-0x66 gives c-0x57.
  - Delimiter: 0x20, 0x0D, 0x0A, 0x2C.
  - Anything else is invalid.
- IDLE:
  - Digit: acc={0,nib}, count=1, go to ACCUM.
  - Delimiter: ignored, stay in IDLE; no empty words are emitted.
  - Invalid: err pulse, go to DRAIN.
- ACCUM:
  - Digit with count<MAXDIG: acc={acc[WIDTH-5:0],nib}, count+1.
  - Digit with count==MAXDIG: overflow; err pulse, acc=0, count=0, go to DRAIN.
  - Delimiter: word_out=acc, word_valid=1, go to OUTPUT.
  - Invalid: err pulse, acc=0, count=0, go to DRAIN.
- OUTPUT:
  - word_out and word_valid are held stable until word_ready.
  - When word_valid && word_ready: word_valid=0, acc=0, count=0, go to IDLE next cycle.
  - No input characters are accepted in OUTPUT.
- DRAIN:
  - All non-delimiter characters are discarded without further err pulses.
  - A delimiter returns the block to IDLE.
- Latency:
  - Delimiter accepted in cycle N: word_valid=1 in cycle N+1.
  - word_ready sampled high in cycle M: char_ready=1 in cycle M+1.
- err is high for exactly one cycle per rejected token, in the cycle after the offending character is accepted.
- Leading zeros count as digits, e.g. "00000000F" with WIDTH=32 is an overflow.
- word_out keeps its last value after the handshake; it is only meaningful while word_valid=1.
- rst_n asserted mid-token or mid-OUTPUT: partial or pending word is discarded, all outputs return to their reset values immediately, no err pulse.

Optional Feature:
- Macro: ASCII_HEX_PARSER_PREFIX_EN.
- Defined:
  - In ACCUM with count==1 and acc==0, a character 0x78 or 0x58 ('x'/'X') clears count to 0 and enters state PFX.
  - PFX behaves as ACCUM, except a delimiter with count==0 gives err pulse and a return to IDLE.
  - The prefix does not count toward MAXDIG.
- Not defined: 'x'/'X' is an invalid character; the PFX state does not exist.

Test Plan:
- Reset, then "1A2b\n" with word_ready=1: one word_valid pulse, word_out=0x00001A2B; err never high; char_ready=1 throughout except the OUTPUT cycle.
- "DEADBEEF " then hold word_ready=0 for 5 cycles while char_valid=1 with "12": word_out=0xDEADBEEF stable, char_ready=0 until the handshake; then "12\n" gives 0x00000012.
- "123456789 42\n": err pulses once (9th digit), no word for the first token; second token gives word_out=0x00000042.
- "1G5 \r\n,7\n": err pulses once on 'G'; repeated delimiters are ignored; exactly one word, 0x00000007.
- rst_n asserted asynchronously after "AB" is accepted, then released: word_valid=0 and digit_count=0 immediately; subsequent "C\n" gives 0x0000000C.
- With ASCII_HEX_PARSER_PREFIX_EN: "0x1F\n" gives 0x0000001F and "0x\n" gives an err pulse. Without it, "0x1F\n" gives an err pulse and no word.

Source files
------------

// File: rtl/ascii_hex_parser_if.sv
// Character-in / word-out handshake bundle for the ASCII hex parser.
// master drives characters and word_ready; slave is the parser itself.
interface ascii_hex_parser_if #(
  parameter int WIDTH = 32
);
  localparam int MAXDIG = WIDTH / 4;
  localparam int CW     = $clog2(MAXDIG + 1);

  logic [7:0]       char_in;
  logic             char_valid;
  logic             char_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CW-1:0]    digit_count;
  logic             err;

  modport master (
    output char_in, char_valid, word_ready,
    input  char_ready, word_out, word_valid, digit_count, err
  );

  modport slave (
    input  char_in, char_valid, word_ready,
    output char_ready, word_out, word_valid, digit_count, err
  );
endinterface

// File: rtl/ascii_hex_parser.sv
// ASCII hex token parser: delimited hex digits -> right-aligned word; 'x'/'X' prefix via ASCII_HEX_PARSER_PREFIX_EN.
// Word valid one cycle after its delimiter; characters stall (char_ready=0) while a word awaits word_ready.
module ascii_hex_parser #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  ascii_hex_parser_if.slave bus
);
  localparam int MAXDIG = WIDTH / 4;
  localparam int CW     = $clog2(MAXDIG + 1);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    OUTPUT,
    DRAIN
`ifdef ASCII_HEX_PARSER_PREFIX_EN
    , PFX
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] word_q;
  logic             word_valid_q;
  logic             err_q;

  logic [7:0] c;
  logic       is_dig;
  logic       is_delim;
  logic [3:0] nib;
  logic       fire;
  logic       pfx_enter;
  logic       pfx_empty;

  assign c = bus.char_in;

  always_comb begin
    is_dig = 1'b0;
    nib    = 4'h0;
    if (c >= 8'h30 && c <= 8'h39) begin
      is_dig = 1'b1;
      nib    = 4'(c - 8'h30);
    end else if (c >= 8'h41 && c <= 8'h46) begin
      is_dig = 1'b1;
      nib    = 4'(c - 8'h37);
    end else if (c >= 8'h61 && c <= 8'h66) begin
      is_dig = 1'b1;
      nib    = 4'(c - 8'h57);
    end
  end

  assign is_delim = (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A) || (c == 8'h2C);

  // No character is taken while a finished word is waiting.
  assign bus.char_ready = (state != OUTPUT);
  assign fire           = bus.char_valid && (state != OUTPUT);

`ifdef ASCII_HEX_PARSER_PREFIX_EN
  // A lone leading '0' followed by x/X is a prefix, not a digit.
  assign pfx_enter = (state == ACCUM) && ((c == 8'h78) || (c == 8'h58)) &&
                     (count == CW'(1)) && (acc == '0);
  assign pfx_empty = (state == PFX) && is_delim && (count == '0);
`else
  assign pfx_enter = 1'b0;
  assign pfx_empty = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            if (is_dig) begin
              acc   <= WIDTH'(nib);
              count <= CW'(1);
              state <= ACCUM;
            end else if (!is_delim) begin
              err_q <= 1'b1;
              state <= DRAIN;
            end
          end
        end
`ifdef ASCII_HEX_PARSER_PREFIX_EN
        ACCUM, PFX: begin
`else
        ACCUM: begin
`endif
          if (fire) begin
            if (pfx_enter) begin
              count <= '0;
`ifdef ASCII_HEX_PARSER_PREFIX_EN
              state <= PFX;
`endif
            end else if (pfx_empty) begin
              err_q <= 1'b1;
              acc   <= '0;
              state <= IDLE;
            end else if (is_dig) begin
              if (count < CW'(MAXDIG)) begin
                acc   <= (acc << 4) | WIDTH'(nib);
                count <= count + CW'(1);
              end else begin
                err_q <= 1'b1;
                acc   <= '0;
                count <= '0;
                state <= DRAIN;
              end
            end else if (is_delim) begin
              word_q       <= acc;
              word_valid_q <= 1'b1;
              state        <= OUTPUT;
            end else begin
              err_q <= 1'b1;
              acc   <= '0;
              count <= '0;
              state <= DRAIN;
            end
          end
        end
        OUTPUT: begin
          if (bus.word_ready) begin
            word_valid_q <= 1'b0;
            acc          <= '0;
            count        <= '0;
            state        <= IDLE;
          end
        end
        DRAIN: begin
          if (fire && is_delim) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.word_out    = word_q;
  assign bus.word_valid  = word_valid_q;
  assign bus.digit_count = count;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_ascii_hex_parser.sv
// Bench for ascii_hex_parser: directed token scenarios plus random character streams
// checked against a token-level reference model.
module tb_ascii_hex_parser;
  localparam int WIDTH  = 32;
  localparam int MAXDIG = WIDTH / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascii_hex_parser_if #(.WIDTH(WIDTH)) bus ();

  ascii_hex_parser #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests   = 0;
  int fails   = 0;
  int got_err = 0;
  int exp_err = 0;
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  rnd_q[$];
  logic [7:0]  str_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_delim(input logic [7:0] c);
    return (c == 8'h20) || (c == 8'h0D) || (c == 8'h0A) || (c == 8'h2C);
  endfunction

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // Reference: one word per well-formed token, one error per bad token.
  function automatic void eval_tok(input logic [7:0] t[$]);
    int start = 0;
    longint unsigned v = 0;
    bit ok = 1'b1;
`ifdef ASCII_HEX_PARSER_PREFIX_EN
    if (t.size() >= 2 && t[0] == "0" && (t[1] == "x" || t[1] == "X")) begin
      start = 2;
      ok    = (t.size() > 2);
    end
`endif
    for (int j = start; j < t.size(); j++) begin
      if (hexval(t[j]) < 0) ok = 1'b0;
      else v = v * 16 + longint'(hexval(t[j]));
    end
    if (t.size() - start > MAXDIG) ok = 1'b0;
    if (ok) exp_q.push_back(v[31:0]);
    else exp_err++;
  endfunction

  function automatic void model(input logic [7:0] s[$]);
    logic [7:0] tok[$];
    exp_q.delete();
    exp_err = 0;
    for (int i = 0; i < s.size(); i++) begin
      if (is_delim(s[i])) begin
        if (tok.size() > 0) eval_tok(tok);
        tok.delete();
      end else begin
        tok.push_back(s[i]);
      end
    end
  endfunction

  task automatic to_q(input string s);
    str_q.delete();
    for (int i = 0; i < s.len(); i++) str_q.push_back(s[i]);
  endtask

  // One clock: record handshakes, count err pulses, check cycle-level rules.
  task automatic tick();
    logic acc, wv0, held;
    logic [7:0] c;
    logic [31:0] wprev;
    acc   = bus.char_valid && bus.char_ready;
    c     = bus.char_in;
    wv0   = bus.word_valid;
    held  = bus.word_valid && !bus.word_ready;
    wprev = bus.word_out;
    if (bus.word_valid && bus.word_ready) got_q.push_back(bus.word_out);
    @(posedge clk);
    #1;
    if (bus.err === 1'b1) got_err++;
    chk("rdy_decode", bus.char_ready, !bus.word_valid);
    if (held) begin
      chk("hold_vld", bus.word_valid, 1);
      chk("hold_dat", bus.word_out, wprev);
    end
    if (!wv0 && bus.word_valid) chk("vld_after_delim", acc && is_delim(c), 1);
    if (bus.err === 1'b1) chk("err_after_accept", acc, 1);
  endtask

  task automatic send_char(input logic [7:0] c);
    logic r;
    int n = 0;
    bus.char_in    = c;
    bus.char_valid = 1'b1;
    do begin
      r = bus.char_ready;
      tick();
      n++;
    end while (!r && n < 50);
    chk("send_accept", r, 1);
    bus.char_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i]);
  endtask

  task automatic run_q(input logic [7:0] s[$], input int vld_pct, input int rdy_pct);
    int idx = 0;
    int guard = 0;
    logic r;
    model(s);
    got_q.delete();
    got_err = 0;
    while (idx < s.size() && guard < 40 * s.size() + 50) begin
      bus.char_valid = ($urandom_range(99) < vld_pct);
      bus.char_in    = bus.char_valid ? s[idx] : 8'($urandom);
      bus.word_ready = ($urandom_range(99) < rdy_pct);
      r = bus.char_valid && bus.char_ready;
      tick();
      if (r) idx++;
      guard++;
    end
    chk("stream_consumed", idx, s.size());
    bus.char_valid = 1'b0;
    bus.word_ready = 1'b1;
    repeat (4) tick();
    chk("n_words", got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("word", got_q[i], exp_q[i]);
    chk("n_err", got_err, exp_err);
    chk("idle_count", bus.digit_count, 0);
  endtask

  task automatic run_str(input string s, input int vld_pct, input int rdy_pct);
    to_q(s);
    run_q(str_q, vld_pct, rdy_pct);
  endtask

  task automatic chk_word(input int idx, input logic [31:0] val);
    if (got_q.size() > idx) chk("exp_word", got_q[idx], val);
    else chk("word_missing", got_q.size(), idx + 1);
  endtask

  task automatic gen();
    string hexs = "0123456789abcdefABCDEF";
    string bads = "Gzx!g:";
    string dels = " \r\n,";
    int ntok, len;
    rnd_q.delete();
    ntok = $urandom_range(1, 6);
    for (int t = 0; t < ntok; t++) begin
      if ($urandom_range(9) == 0) begin
        rnd_q.push_back("0");
        rnd_q.push_back($urandom_range(1) ? "x" : "X");
      end
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(99) < 4) rnd_q.push_back(bads[$urandom_range(bads.len() - 1)]);
        else rnd_q.push_back(hexs[$urandom_range(hexs.len() - 1)]);
      end
      repeat ($urandom_range(1, 2)) rnd_q.push_back(dels[$urandom_range(dels.len() - 1)]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

  initial begin
    bus.char_in    = 8'h00;
    bus.char_valid = 1'b0;
    bus.word_ready = 1'b1;
    #12;
    chk("rst_word_valid", bus.word_valid, 0);
    chk("rst_word_out", bus.word_out, 0);
    chk("rst_count", bus.digit_count, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", bus.char_ready, 1);

    run_str("1A2b\n", 100, 100);
    chk_word(0, 32'h00001A2B);
    chk("t1_err", got_err, 0);

    // Backpressure: word held while characters are refused.
    got_q.delete();
    got_err = 0;
    bus.word_ready = 1'b0;
    send_str("DEADBEEF ");
    chk("t2_vld", bus.word_valid, 1);
    chk("t2_dat", bus.word_out, 32'hDEADBEEF);
    bus.char_in    = "1";
    bus.char_valid = 1'b1;
    repeat (5) begin
      tick();
      chk("t2_stall_rdy", bus.char_ready, 0);
      chk("t2_stall_dat", bus.word_out, 32'hDEADBEEF);
    end
    bus.word_ready = 1'b1;
    tick();
    chk("t2_vld_drop", bus.word_valid, 0);
    chk("t2_rdy_back", bus.char_ready, 1);
    chk("t2_count", bus.digit_count, 0);
    send_str("12\n");
    repeat (3) tick();
    chk("t2_nwords", got_q.size(), 2);
    chk_word(0, 32'hDEADBEEF);
    chk_word(1, 32'h00000012);

    run_str("123456789 42\n", 100, 100);
    chk("t3_err", got_err, 1);
    chk_word(0, 32'h00000042);

    run_str("1G5 \r\n,7\n", 100, 100);
    chk("t4_err", got_err, 1);
    chk("t4_nwords", got_q.size(), 1);
    chk_word(0, 32'h00000007);

    run_str("FFFFFFFF 00000000F\n", 100, 100);
    chk_word(0, 32'hFFFFFFFF);
    chk("t_ovf_err", got_err, 1);

    // Asynchronous reset in the middle of a token.
    got_err = 0;
    send_str("AB");
    chk("t5_count_pre", bus.digit_count, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_vld", bus.word_valid, 0);
    chk("t5_count", bus.digit_count, 0);
    chk("t5_err", bus.err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_str("C\n", 100, 100);
    chk_word(0, 32'h0000000C);

`ifdef ASCII_HEX_PARSER_PREFIX_EN
    run_str("0x1F\n", 100, 100);
    chk_word(0, 32'h0000001F);
    chk("pfx_ok_err", got_err, 0);
    run_str("0x\n", 100, 100);
    chk("pfx_empty_err", got_err, 1);
    chk("pfx_empty_nw", got_q.size(), 0);
`else
    run_str("0x1F\n", 100, 100);
    chk("nopfx_err", got_err, 1);
    chk("nopfx_nw", got_q.size(), 0);
`endif

    for (int k = 0; k < 40; k++) begin
      gen();
      run_q(rnd_q, $urandom_range(30, 100), $urandom_range(20, 100));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
